// File: rtl/mux_scan_serializer.sv
// Walks a mux select from 0 to N-1, presents each sampled bit as a valid/ready serial
// stream, rebuilds the scanned word and pulses done after the last bit is accepted.
module mux_scan_serializer #(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          abort_i,
  output logic [SW-1:0] sel_o,
  input  logic          mux_bit_i,
  output logic          ser_valid_o,
  output logic          ser_data_o,
  input  logic          ser_ready_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [N-1:0]  word_out_o
);

  typedef enum logic [1:0] {IDLE, SETUP, PRESENT, DONE} state_t;

  localparam logic [SW-1:0] LAST_SEL = SW'(N - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          vld_q, vld_d;
  logic          dat_q, dat_d;
  logic [N-1:0]  word_q, word_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      vld_q   <= 1'b0;
      dat_q   <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        // abort beats a same-cycle start, so the scan never begins
        if (start_i && !abort_i) begin
          state_d = SETUP;
          sel_d   = '0;
          word_d  = '0;
        end
      end
      SETUP: begin
        if (abort_i) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          sel_d   = '0;
        end else begin
          dat_d         = mux_bit_i;
          word_d[sel_q] = mux_bit_i;
          vld_d         = 1'b1;
          state_d       = PRESENT;
        end
      end
      PRESENT: begin
        if (abort_i) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          sel_d   = '0;
        end else if (vld_q && ser_ready_i) begin
          vld_d = 1'b0;
          if (sel_q == LAST_SEL) begin
            state_d = DONE;
          end else begin
            sel_d   = sel_q + SW'(1);
            state_d = SETUP;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        sel_d   = '0;
        vld_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  assign sel_o       = sel_q;
  assign ser_valid_o = vld_q;
  assign ser_data_o  = dat_q;
  assign word_out_o  = word_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench for mux_scan_serializer: cycle table for the basic scan plus
// hand-written sequences for backpressure, ignored start, abort, reset and N=5.
module tb_mux_scan_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance
  logic       st8 = 0, ab8 = 0, rdy8 = 0;
  logic [7:0] mux_data8 = '0;
  logic [2:0] sel8;
  logic       mux_bit8, vld8, dat8, busy8, done8;
  logic [7:0] word8;
  assign mux_bit8 = mux_data8[sel8];

  mux_scan_serializer #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(st8), .abort_i(ab8), .sel_o(sel8),
    .mux_bit_i(mux_bit8), .ser_valid_o(vld8), .ser_data_o(dat8),
    .ser_ready_i(rdy8), .busy_o(busy8), .done_o(done8), .word_out_o(word8)
  );

  // N=5 instance
  logic       st5 = 0, ab5 = 0, rdy5 = 0;
  logic [4:0] mux_data5 = '0;
  logic [2:0] sel5;
  logic       mux_bit5, vld5, dat5, busy5, done5;
  logic [4:0] word5;
  assign mux_bit5 = mux_data5[sel5];

  mux_scan_serializer #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .start_i(st5), .abort_i(ab5), .sel_o(sel5),
    .mux_bit_i(mux_bit5), .ser_valid_o(vld5), .ser_data_o(dat5),
    .ser_ready_i(rdy5), .busy_o(busy5), .done_o(done5), .word_out_o(word5)
  );

  // Handshake / done monitors; an aborted cycle is not an accepted bit.
  logic bits8[$];
  logic bits5[$];
  int   dn8 = 0, dn5 = 0, max_sel5 = 0;
  always @(posedge clk) begin
    if (rst_n && vld8 && rdy8 && !ab8) bits8.push_back(dat8);
    if (rst_n && done8) dn8 = dn8 + 1;
    if (rst_n && vld5 && rdy5 && !ab5) bits5.push_back(dat5);
    if (rst_n && done5) dn5 = dn5 + 1;
    if (int'(sel5) > max_sel5) max_sel5 = int'(sel5);
  end

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       start;
    logic       abort;
    logic [2:0] sel;
    logic       vld;
    logic       dat;
    logic       busy;
    logic       done;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic a, input logic [2:0] sl,
                              input logic v, input logic d, input logic b, input logic dn);
    vec_t r;
    r.start = s; r.abort = a; r.sel = sl; r.vld = v; r.dat = d; r.busy = b; r.done = dn;
    return r;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Advance until done8 is high; returns cycles advanced, or -1 on timeout.
  task automatic wait_done8(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (done8) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic chk_stream8(input string name, input int base, input logic [7:0] exp);
    logic [7:0] w;
    chk({name, "_count"}, bits8.size() - base, 8);
    if (bits8.size() >= base + 8) begin
      for (int k = 0; k < 8; k++) w[k] = bits8[base + k];
      chk({name, "_order"}, w, exp);
    end
  endtask

  vec_t tbl[21];

  initial begin
    int base, d0, cyc;
    logic found;

    // A5 = bits 1,0,1,0,0,1,0,1 (index ascending); start accepted at entry 2 (cycle T)
    tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 0);
    tbl[4]  = mk(0, 0, 0, 1, 1, 1, 0);
    tbl[5]  = mk(0, 0, 1, 0, 1, 1, 0);
    tbl[6]  = mk(0, 0, 1, 1, 0, 1, 0);
    tbl[7]  = mk(0, 0, 2, 0, 0, 1, 0);
    tbl[8]  = mk(0, 0, 2, 1, 1, 1, 0);
    tbl[9]  = mk(0, 0, 3, 0, 1, 1, 0);
    tbl[10] = mk(0, 0, 3, 1, 0, 1, 0);
    tbl[11] = mk(0, 0, 4, 0, 0, 1, 0);
    tbl[12] = mk(0, 0, 4, 1, 0, 1, 0);
    tbl[13] = mk(0, 0, 5, 0, 0, 1, 0);
    tbl[14] = mk(0, 0, 5, 1, 1, 1, 0);
    tbl[15] = mk(0, 0, 6, 0, 1, 1, 0);
    tbl[16] = mk(0, 0, 6, 1, 0, 1, 0);
    tbl[17] = mk(0, 0, 7, 0, 0, 1, 0);
    tbl[18] = mk(0, 0, 7, 1, 1, 1, 0);
    tbl[19] = mk(0, 0, 7, 0, 1, 1, 1);
    tbl[20] = mk(0, 0, 0, 0, 1, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", sel8, 0);
    chk("rst_vld", vld8, 0);
    chk("rst_dat", dat8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_word", word8, 0);
    rst_n = 1'b1;
    step();

    // 1: full scan of A5, cycle-accurate
    mux_data8 = 8'hA5;
    rdy8 = 1'b1;
    for (int i = 0; i < 21; i++) begin
      st8 = tbl[i].start;
      ab8 = tbl[i].abort;
      #1;
      chk($sformatf("t1_sel[%0d]", i), sel8, tbl[i].sel);
      chk($sformatf("t1_vld[%0d]", i), vld8, tbl[i].vld);
      chk($sformatf("t1_dat[%0d]", i), dat8, tbl[i].dat);
      chk($sformatf("t1_busy[%0d]", i), busy8, tbl[i].busy);
      chk($sformatf("t1_done[%0d]", i), done8, tbl[i].done);
      step();
    end
    st8 = 0;
    ab8 = 0;
    chk("t1_word", word8, 8'hA5);

    // 2: backpressure on bit 3 for 5 cycles
    mux_data8 = 8'h3C;
    base = bits8.size();
    d0 = dn8;
    st8 = 1;
    step();
    st8 = 0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (sel8 == 3'd3 && vld8) begin
        found = 1;
        break;
      end
      step();
    end
    chk("t2_reach_bit3", found, 1);
    rdy8 = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t2_hold_vld[%0d]", i), vld8, 1);
      chk($sformatf("t2_hold_dat[%0d]", i), dat8, 1);
      chk($sformatf("t2_hold_sel[%0d]", i), sel8, 3);
    end
    rdy8 = 1;
    wait_done8(60, cyc);
    chk("t2_done_seen", (cyc > 0), 1);
    step();
    chk("t2_done_count", dn8 - d0, 1);
    chk_stream8("t2_stream", base, 8'h3C);
    chk("t2_word", word8, 8'h3C);

    // 3: start pulses at T+3 and T+9 are ignored
    mux_data8 = 8'h96;
    base = bits8.size();
    d0 = dn8;
    st8 = 1;
    for (int c = 1; c <= 25; c++) begin
      step();
      st8 = (c == 3 || c == 9);
    end
    st8 = 0;
    chk("t3_done_count", dn8 - d0, 1);
    chk_stream8("t3_stream", base, 8'h96);
    chk("t3_word", word8, 8'h96);
    chk("t3_idle", busy8, 0);

    // 4: abort in PRESENT at sel=4, colliding with a handshake
    mux_data8 = 8'hFF;
    base = bits8.size();
    d0 = dn8;
    st8 = 1;
    step();
    st8 = 0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (sel8 == 3'd4 && vld8) begin
        found = 1;
        break;
      end
      step();
    end
    chk("t4_reach_bit4", found, 1);
    ab8 = 1;
    step();
    ab8 = 0;
    chk("t4_busy", busy8, 0);
    chk("t4_vld", vld8, 0);
    chk("t4_sel", sel8, 0);
    chk("t4_word", word8, 8'h1F);
    chk("t4_accepted", bits8.size() - base, 4);
    repeat (3) step();
    chk("t4_no_done", dn8 - d0, 0);
    base = bits8.size();
    st8 = 1;
    step();
    st8 = 0;
    wait_done8(60, cyc);
    chk("t4_rescan_done", cyc, 16);
    step();
    chk_stream8("t4_rescan", base, 8'hFF);
    chk("t4_rescan_word", word8, 8'hFF);

    // 5: asynchronous reset mid-scan
    mux_data8 = 8'hA7;
    d0 = dn8;
    st8 = 1;
    step();
    st8 = 0;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (sel8 == 3'd2) begin
        found = 1;
        break;
      end
      step();
    end
    chk("t5_reach_sel2", found, 1);
    #2;
    rst_n = 0;
    #1;
    chk("t5_rst_sel", sel8, 0);
    chk("t5_rst_vld", vld8, 0);
    chk("t5_rst_dat", dat8, 0);
    chk("t5_rst_busy", busy8, 0);
    chk("t5_rst_done", done8, 0);
    chk("t5_rst_word", word8, 0);
    step();
    rst_n = 1;
    step();
    chk("t5_no_done", dn8 - d0, 0);
    base = bits8.size();
    st8 = 1;
    step();
    st8 = 0;
    wait_done8(60, cyc);
    chk("t5_rescan_done", cyc, 16);
    step();
    chk_stream8("t5_rescan", base, 8'hA7);
    chk("t5_rescan_word", word8, 8'hA7);

    // 5b: N=5, data 5'b10110, ready held high
    mux_data5 = 5'b10110;
    rdy5 = 1;
    max_sel5 = 0;
    d0 = dn5;
    st5 = 1;
    step();
    st5 = 0;
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      if (done5) begin
        cyc = i;
        break;
      end
      step();
    end
    chk("t5n5_done_cycle", cyc, 11);
    step();
    chk("t5n5_done_count", dn5 - d0, 1);
    chk("t5n5_max_sel", max_sel5, 4);
    chk("t5n5_word", word5, 5'h16);
    chk("t5n5_count", bits5.size(), 5);
    if (bits5.size() >= 5) begin
      logic [4:0] w5;
      for (int k = 0; k < 5; k++) w5[k] = bits5[k];
      chk("t5n5_order", w5, 5'h16);
    end
    chk("t5n5_idle", busy5, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
